// File: rtl/mem_responder_pkg.sv
// Shared types and defaults for the CPU memory responder and its boot loader.
package mem_responder_pkg;

    localparam int unsigned DEF_ADDR_BITS  = 8;
    localparam int unsigned DEF_BOOT_WORDS = 64;
    localparam int unsigned WORD_BYTES     = 4;

    typedef enum logic {
        ST_BOOT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Index of the final byte the loader accepts before releasing the CPU.
    function automatic int unsigned boot_last_byte(input int unsigned words);
        return words * WORD_BYTES - 1;
    endfunction

endpackage

// File: rtl/mem_responder.sv
// Byte-addressed little-endian word memory with one-cycle read latency,
// a streaming boot loader that holds the CPU until the image is loaded, and range fault flagging.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int unsigned ADDR_BITS  = DEF_ADDR_BITS,
    parameter int unsigned BOOT_WORDS = DEF_BOOT_WORDS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cpu_addr,
    input  logic        cpu_wr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_hold,
    output logic        addr_fault,
    input  logic [7:0]  boot_byte,
    input  logic        boot_valid,
    output logic        boot_ready,
    output logic        boot_done
);

    localparam int unsigned CNT_W  = ADDR_BITS + 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_BITS;
    localparam int unsigned WIDX_W = ADDR_BITS - 2;
    localparam logic [CNT_W-1:0] LAST_BYTE = CNT_W'(boot_last_byte(BOOT_WORDS));

    state_e             state;
    logic [CNT_W-1:0]   byte_cnt;
    logic [7:0]         mem [DEPTH];

    logic               boot_fire_c;
    logic               in_range_c;
    logic               cpu_we_c;
    logic [WIDX_W-1:0]  widx_c;
    logic [ADDR_BITS-1:0] boot_addr_c;
    logic               unused_addr_lsb_c;

    assign boot_fire_c       = boot_valid & boot_ready;
    assign boot_addr_c       = byte_cnt[ADDR_BITS-1:0];
    assign in_range_c        = (cpu_addr[31:ADDR_BITS] == '0);
    assign widx_c            = cpu_addr[ADDR_BITS-1:2];
    assign cpu_we_c          = (state == ST_RUN) & cpu_wr & in_range_c;
    // Sub-word address bits alias to the containing word.
    assign unused_addr_lsb_c = ^cpu_addr[1:0];

    // Boot FSM: counts accepted bytes and releases the CPU after the last one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_BOOT;
            byte_cnt   <= '0;
            boot_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            boot_done  <= 1'b0;
        end else if (state == ST_BOOT && boot_fire_c) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
            if (byte_cnt == LAST_BYTE) begin
                state      <= ST_RUN;
                boot_ready <= 1'b0;
                cpu_hold   <= 1'b0;
                boot_done  <= 1'b1;
            end
        end
    end

    // Storage is never cleared; loader and CPU writes are mutually exclusive by state.
    always_ff @(posedge clk) begin
        if (boot_fire_c) begin
            mem[boot_addr_c] <= boot_byte;
        end
        if (cpu_we_c) begin
            for (int k = 0; k < 4; k++) begin
                mem[{widx_c, 2'(k)}] <= cpu_wdata[8*k +: 8];
            end
        end
    end

    // Read port returns the pre-write word on a same-cycle read/write.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cpu_rdata  <= '0;
            addr_fault <= 1'b0;
        end else if (state == ST_RUN) begin
            cpu_rdata  <= in_range_c ? {mem[{widx_c, 2'd3}], mem[{widx_c, 2'd2}],
                                        mem[{widx_c, 2'd1}], mem[{widx_c, 2'd0}]} : '0;
            addr_fault <= ~in_range_c;
        end else begin
            cpu_rdata  <= '0;
            addr_fault <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected outputs, a negedge monitor checks them.
module tb_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] cpu_addr;
    logic        cpu_wr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_hold;
    logic        addr_fault;
    logic [7:0]  boot_byte;
    logic        boot_valid;
    logic        boot_ready;
    logic        boot_done;

    mem_responder #(.ADDR_BITS(8), .BOOT_WORDS(64)) dut (
        .clk        (clk),
        .reset      (reset),
        .cpu_addr   (cpu_addr),
        .cpu_wr     (cpu_wr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .addr_fault (addr_fault),
        .boot_byte  (boot_byte),
        .boot_valid (boot_valid),
        .boot_ready (boot_ready),
        .boot_done  (boot_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned due;
        string       name;
        logic [31:0] rdata;
        logic        fault;
        logic        done;
        logic        hold;
        logic        ready;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Queue the outputs required after the next rising edge.
    task automatic expect_next(input string name, input logic [31:0] rd, input logic f,
                               input logic d, input logic h, input logic r);
        exp_t e;
        e.due   = cyc + 1;
        e.name  = name;
        e.rdata = rd;
        e.fault = f;
        e.done  = d;
        e.hold  = h;
        e.ready = r;
        sb.push_back(e);
    endtask

    task automatic expect_boot(input string name);
        expect_next(name, 32'h0, 1'b0, 1'b0, 1'b1, 1'b1);
    endtask

    // Monitor: compare every due entry on the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            tests++;
            if (e.due != cyc || cpu_rdata !== e.rdata || addr_fault !== e.fault ||
                boot_done !== e.done || cpu_hold !== e.hold || boot_ready !== e.ready) begin
                fails++;
                $display("FAIL %s: got rdata=%h fault=%b done=%b hold=%b ready=%b (cyc %0d), need rdata=%h fault=%b done=%b hold=%b ready=%b (cyc %0d)",
                         e.name, cpu_rdata, addr_fault, boot_done, cpu_hold, boot_ready, cyc,
                         e.rdata, e.fault, e.done, e.hold, e.ready, e.due);
            end
        end
    end

    task automatic cpu_access(input logic [31:0] a, input logic wr, input logic [31:0] wd,
                              input string name, input logic [31:0] rd, input logic f);
        @(negedge clk);
        cpu_addr  = a;
        cpu_wr    = wr;
        cpu_wdata = wd;
        expect_next(name, rd, f, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic cpu_idle();
        @(negedge clk);
        cpu_wr   = 1'b0;
        cpu_addr = 32'h0;
    endtask

    task automatic pulse_reset(input string name);
        @(negedge clk);
        reset = 1'b0;
        expect_boot(name);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Stream n boot bytes (value = index, or 0xEE), optionally with idle gaps and CPU noise.
    task automatic stream(input int n, input bit gaps, input bit fixed_ee, input bit cpu_noise);
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                int g = int'($urandom_range(0, 2));
                repeat (g) begin
                    @(negedge clk);
                    boot_valid = 1'b0;
                    boot_byte  = 8'h5A;
                end
            end
            @(negedge clk);
            boot_valid = 1'b1;
            boot_byte  = fixed_ee ? 8'hEE : 8'(i);
            if (cpu_noise) begin
                cpu_wr    = 1'b1;
                cpu_wdata = 32'hAAAA_AAAA;
                cpu_addr  = (i < 128) ? 32'h0000_0300 : 32'h0000_0000;
            end
            if (i == 255)
                expect_next($sformatf("boot release byte %0d", i), 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
            else if (i % 64 == 0 || i == 254)
                expect_boot($sformatf("boot byte %0d", i));
        end
        @(negedge clk);
        boot_valid = 1'b0;
        cpu_wr     = 1'b0;
        cpu_addr   = 32'h0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b0;
        cpu_addr   = 32'h0;
        cpu_wr     = 1'b0;
        cpu_wdata  = 32'h0;
        boot_byte  = 8'h0;
        boot_valid = 1'b0;

        // Reset state, then T1 full boot and basic reads
        pulse_reset("reset state");
        stream(256, 1'b0, 1'b0, 1'b0);
        cpu_access(32'h04, 1'b0, 32'h0, "T1 read 0x04", 32'h0706_0504, 1'b0);
        cpu_access(32'hFC, 1'b0, 32'h0, "T1 read top 0xFC", 32'hFFFE_FDFC, 1'b0);
        cpu_access(32'h07, 1'b0, 32'h0, "T1 misaligned 0x07", 32'h0706_0504, 1'b0);

        // T3 read-during-write returns old word, new word visible next
        cpu_access(32'h10, 1'b1, 32'hDEAD_BEEF, "T3 rdw old", 32'h1312_1110, 1'b0);
        cpu_access(32'h12, 1'b0, 32'h0, "T3 read new", 32'hDEAD_BEEF, 1'b0);

        // T4 out-of-range access
        cpu_access(32'h100, 1'b1, 32'hFFFF_FFFF, "T4 oob write", 32'h0, 1'b1);
        cpu_access(32'h00, 1'b0, 32'h0, "T4 read 0x00", 32'h0302_0100, 1'b0);
        cpu_access(32'h8000_0000, 1'b0, 32'h0, "T4 held bad a", 32'h0, 1'b1);
        cpu_access(32'h8000_0000, 1'b0, 32'h0, "T4 held bad b", 32'h0, 1'b1);
        cpu_access(32'hFC, 1'b0, 32'h0, "T4 top intact", 32'hFFFE_FDFC, 1'b0);

        // T2 reboot with gaps restores overwritten words
        cpu_access(32'h20, 1'b1, 32'h1111_1111, "T2 pre write", 32'h2322_2120, 1'b0);
        cpu_access(32'h20, 1'b0, 32'h0, "T2 pre read", 32'h1111_1111, 1'b0);
        cpu_idle();
        pulse_reset("T2 reset");
        stream(256, 1'b1, 1'b0, 1'b0);
        cpu_access(32'h20, 1'b0, 32'h0, "T2 read 0x20", 32'h2322_2120, 1'b0);
        cpu_access(32'h10, 1'b0, 32'h0, "T2 read 0x10", 32'h1312_1110, 1'b0);
        cpu_access(32'hFC, 1'b0, 32'h0, "T2 read 0xFC", 32'hFFFE_FDFC, 1'b0);
        cpu_idle();

        // T5 reset mid-boot restarts from byte 0
        pulse_reset("T5 reset");
        stream(10, 1'b0, 1'b1, 1'b0);
        pulse_reset("T5 mid-boot reset");
        stream(256, 1'b0, 1'b0, 1'b0);
        cpu_access(32'h00, 1'b0, 32'h0, "T5 read 0x00", 32'h0302_0100, 1'b0);
        cpu_access(32'h08, 1'b0, 32'h0, "T5 read 0x08", 32'h0B0A_0908, 1'b0);
        cpu_idle();

        // T6 CPU traffic during boot is ignored
        pulse_reset("T6 reset");
        stream(256, 1'b0, 1'b0, 1'b1);
        cpu_access(32'h00, 1'b0, 32'h0, "T6 read 0x00", 32'h0302_0100, 1'b0);
        cpu_access(32'h300, 1'b0, 32'h0, "T6 run oob", 32'h0, 1'b1);
        cpu_idle();

        for (int k = 0; k < 20 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            tests++;
            fails++;
            $display("FAIL scoreboard drain: %0d entries pending, need 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
